stack_guard: RTL
================

Name: stack_guard

Overview:
- Sits directly upstream of the 128×32 CPU hardware stack, between the CPU execute stage and the stack RAM.
- Filters CPU push/pop commands and tracks stack depth.
- Blocks overflow, underflow and illegal simultaneous commands so the stack pointer never wraps, and raises an interrupt on each blocked command.
- Tags pop return data with a valid strobe and exposes full/empty/depth status to the CPU.

Parameters:
- DW, 32, data width of one stack entry.
- DEPTH, 128, number of entries in the downstream stack.
- CW, 8, depth counter width; must hold 0..DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_push  in  1  push request; valid for a single clk cycle.
- cpu_pop  in  1  pop request; valid for a single clk cycle.
- cpu_d  in  DW  push data.
- cpu_q  out  DW  pop result.
- cpu_q_valid  out  1  one-cycle strobe; cpu_q is valid.
- flush  in  1  synchronous request to empty the stack.
- stk_push  out  1  push to stack.
- stk_pop  out  1  pop to stack.
- stk_d  out  DW  data to stack.
- stk_q  in  DW  registered stack output, valid the cycle after stk_pop.
- stk_reset  out  1  active-high synchronous reset to stack.
- depth  out  CW  current entry count.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- intr  out  1  one-cycle interrupt pulse.
- err_status  out  3  sticky flags {both, underflow, overflow}.
- err_clear  in  1  clears err_status.

Behaviour:
- Reset (reset low, async) forces all outputs to 0 except empty=1.
  - depth=0, err_status=0, state=IDLE.
  - stk_reset is held 1 while reset is low, and for one cycle after release.
- stk_push, stk_pop, stk_d and stk_reset are combinational from inputs and registered state. Everything else is registered.
- States:
  - IDLE: normal operation.
  - FLUSH: stk_reset=1 for exactly one cycle.
  - Transitions: IDLE→FLUSH when flush=1; FLUSH→IDLE unconditionally.
  - While in FLUSH, cpu_push and cpu_pop are ignored (not flagged). depth←0 on entry.
- Legal push (IDLE, cpu_push=1, cpu_pop=0, !full):
  - stk_push=1, stk_d=cpu_d.
  - depth+1 at the next edge.
- Legal pop (IDLE, cpu_pop=1, cpu_push=0, !empty):
  - stk_pop=1; depth−1 at the next edge.
  - The next cycle: cpu_q_valid=1, cpu_q=stk_q (passthrough, one-cycle latency total).
- Overflow (push when full):
  - stk_push=0, depth unchanged.
  - err_status[0]←1; intr=1 on the next cycle.
- Underflow (pop when empty):
  - stk_pop=0.
  - The next cycle: cpu_q_valid=1, cpu_q=0, err_status[1]←1, intr=1. Return latency is identical to a legal pop.
- Both cpu_push and cpu_pop high:
  - Neither is forwarded; depth unchanged.
  - err_status[2]←1, intr=1.
- Back-to-back pops are permitted every cycle; each produces one cpu_q_valid in order.
- Push/pop alternation is permitted every cycle.
- flush has priority over cpu_push and cpu_pop in the same cycle; that command is dropped silently.
- Error flags and clear:
  - err_clear clears err_status at the edge.
  - If a new error sets the same cycle, set wins.
  - intr fires once per erroneous command, regardless of sticky state.
- full, empty and depth are derived from the registered depth, updated at the same edge as stk_push/stk_pop.
- depth never exceeds DEPTH and never underflows.
- Reset asserted mid-operation:
  - A pending cpu_q_valid is cancelled.
  - The stack contents are not cleared; only the pointer is cleared, via stk_reset.

Decomposition:
- Shared CPU package:
  - STACK_DW and STACK_DEPTH constants.
  - Error bit indices: ERR_OVF=0, ERR_UNF=1, ERR_BOTH=2.
  - State encoding for IDLE/FLUSH.
- No sub-module needed. The depth counter and state register stay inline.
- The bench instantiates stack_guard together with the existing stack module.

Test Plan:
- Push 0x11111111, 0x22222222, then pop twice → cpu_q_valid on cycles +1 after each pop; cpu_q=0x22222222 then 0x11111111; depth 2→0, empty=1, intr never set.
- Push 128 entries, then a 129th push of 0xDEADBEEF → full=1, stk_push=0 on the 129th, err_status=3'b001, intr one-cycle pulse; popping then returns entry 127's value, not 0xDEADBEEF.
- Pop at reset state → stk_pop=0, next cycle cpu_q_valid=1, cpu_q=0, err_status=3'b010, intr pulse; then err_clear → err_status=0.
- cpu_push and cpu_pop high together with depth=3 → no stk strobes, depth stays 3, err_status=3'b100, intr pulse.
- Push 5 entries, flush concurrent with a push → stk_reset high one cycle, depth=0, empty=1, the concurrent push is not forwarded, no intr.
- Assert reset low asynchronously mid-stream (between edges, during a pop) → outputs clear immediately, cpu_q_valid not emitted, depth=0, stk_reset held until one cycle after release.

Source files
------------

// File: rtl/stack_guard_pkg.sv
// Shared constants and types for the CPU hardware-stack guard.
// Error-bit positions are shared with software that decodes err_status.
package stack_guard_pkg;

  localparam int STACK_DW    = 32;
  localparam int STACK_DEPTH = 128;

  localparam int ERR_OVF  = 0;
  localparam int ERR_UNF  = 1;
  localparam int ERR_BOTH = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/stack_guard.sv
// Push/pop filter in front of the CPU hardware stack: tracks depth, blocks
// overflow/underflow/simultaneous commands and flags each blocked command.
module stack_guard
  import stack_guard_pkg::*;
#(
  parameter int DW    = STACK_DW,
  parameter int DEPTH = STACK_DEPTH,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_push,
  input  logic          cpu_pop,
  input  logic [DW-1:0] cpu_d,
  output logic [DW-1:0] cpu_q,
  output logic          cpu_q_valid,
  input  logic          flush,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_d,
  input  logic [DW-1:0] stk_q,
  output logic          stk_reset,
  output logic [CW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          intr,
  output logic [2:0]    err_status,
  input  logic          err_clear
);

  state_e        state_q, state_d;
  logic [CW-1:0] depth_q, depth_d;
  logic [2:0]    err_q, err_d;
  logic          intr_q, intr_d;
  logic          qv_q, qv_d;
  logic          qsel_q, qsel_d;
  logic          rst_hold_q;
  logic [2:0]    new_err;

  assign full  = (depth_q == CW'(DEPTH));
  assign empty = (depth_q == '0);

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    qv_d     = 1'b0;
    qsel_d   = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    new_err  = '0;

    if (state_q == ST_FLUSH) begin
      state_d = ST_IDLE;
    end else if (!rst_hold_q) begin
      if (flush) begin
        state_d = ST_FLUSH;
        depth_d = '0;
      end else if (cpu_push && cpu_pop) begin
        new_err[ERR_BOTH] = 1'b1;
      end else if (cpu_push) begin
        if (full) begin
          new_err[ERR_OVF] = 1'b1;
        end else begin
          stk_push = 1'b1;
          depth_d  = depth_q + CW'(1);
        end
      end else if (cpu_pop) begin
        // Underflow still returns a (zero) word with the same latency as a real pop.
        qv_d = 1'b1;
        if (empty) begin
          new_err[ERR_UNF] = 1'b1;
        end else begin
          stk_pop = 1'b1;
          qsel_d  = 1'b1;
          depth_d = depth_q - CW'(1);
        end
      end
    end

    err_d  = (err_clear ? 3'b000 : err_q) | new_err;
    intr_d = |new_err;
  end

  // Pointer reset covers reset assertion, the cycle after release and FLUSH.
  assign stk_reset   = rst_hold_q || (state_q == ST_FLUSH);
  assign stk_d       = stk_push ? cpu_d : '0;
  assign cpu_q       = qsel_q ? stk_q : '0;
  assign cpu_q_valid = qv_q;
  assign depth       = depth_q;
  assign intr        = intr_q;
  assign err_status  = err_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      depth_q    <= '0;
      err_q      <= '0;
      intr_q     <= 1'b0;
      qv_q       <= 1'b0;
      qsel_q     <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      err_q      <= err_d;
      intr_q     <= intr_d;
      qv_q       <= qv_d;
      qsel_q     <= qsel_d;
      rst_hold_q <= 1'b0;
    end
  end

endmodule
